// File: rtl/ext_byte_if.sv
// rtl/ext_byte_if.sv - request/result bundle between load path and ext_byte
interface ext_byte_if;
    logic        in_valid;
    logic [1:0]  op;
    logic        isu;
    logic [1:0]  addr_lo;
    logic [31:0] din;
    logic [31:0] dout;
    logic        out_valid;
    logic        misalign;

    modport master (
        output in_valid, op, isu, addr_lo, din,
        input  dout, out_valid, misalign
    );

    modport slave (
        input  in_valid, op, isu, addr_lo, din,
        output dout, out_valid, misalign
    );
endinterface

// File: rtl/ext_byte.sv
// rtl/ext_byte.sv - load-data byte/half/word select and extend, one register stage
// Optional MISALIGN_TRAP_EN: flag misaligned half/word requests and zero their result.
module ext_byte #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    ext_byte_if.slave  bus
);
    localparam logic [1:0] OP_BYTE = 2'd0;
    localparam logic [1:0] OP_HALF = 2'd1;
    localparam logic [1:0] OP_LUI  = 2'd2;
    localparam logic [1:0] OP_WORD = 2'd3;

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] result;
    logic [31:0] dout_q;
    logic        valid_q;

    always_comb begin
        sel_byte = bus.din[7:0];
        case (bus.addr_lo)
            2'd0: sel_byte = bus.din[7:0];
            2'd1: sel_byte = bus.din[15:8];
            2'd2: sel_byte = bus.din[23:16];
            2'd3: sel_byte = bus.din[31:24];
            default: sel_byte = bus.din[7:0];
        endcase
    end

    // addr_lo[0] never steers the halfword mux; misalignment is a separate flag
    assign sel_half = bus.addr_lo[1] ? bus.din[31:16] : bus.din[15:0];

    always_comb begin
        result = bus.din;
        case (bus.op)
            OP_BYTE: result = bus.isu ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            OP_HALF: result = bus.isu ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
            OP_LUI:  result = {bus.din[15:0], 16'b0};
            OP_WORD: result = bus.din;
            default: result = bus.din;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic mis_c;
    logic mis_q;

    always_comb begin
        mis_c = 1'b0;
        if (bus.op == OP_HALF && bus.addr_lo[0])
            mis_c = 1'b1;
        else if (bus.op == OP_WORD && bus.addr_lo != 2'd0)
            mis_c = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            mis_q   <= bus.in_valid & mis_c;
            if (bus.in_valid)
                dout_q <= mis_c ? 32'b0 : result;
        end
    end

    assign bus.misalign = mis_q;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid)
                dout_q <= result;
        end
    end

    assign bus.misalign = 1'b0;
`endif

    assign bus.dout      = dout_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_ext_byte.sv
// tb/tb_ext_byte.sv - vector table plus scoreboard bench for ext_byte
module tb_ext_byte;
    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic        isu;
        logic [1:0]  a;
        logic [31:0] din;
        logic [31:0] dout;
        logic        mis;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] dout;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic [31:0] last_dout = 32'b0;
    exp_t sb[$];
    vec_t vecs[$];

    ext_byte_if bus();

    ext_byte #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic isu,
                                   input logic [1:0] a, input logic [31:0] din);
        exp_t e;
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = din >> (8 * a);
        b  = sh[7:0];
        h  = a[1] ? din[31:16] : din[15:0];
        e.v   = 1'b1;
        e.mis = 1'b0;
        case (op)
            2'd0:    e.dout = isu ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    e.dout = isu ? {16'h0, h} : {{16{h[15]}}, h};
            2'd2:    e.dout = {din[15:0], 16'h0};
            default: e.dout = din;
        endcase
`ifdef MISALIGN_TRAP_EN
        if ((op == 2'd1 && a[0]) || (op == 2'd3 && a != 2'd0)) begin
            e.mis  = 1'b1;
            e.dout = 32'h0;
        end
`endif
        return e;
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic isu,
                         input logic [1:0] a, input logic [31:0] din,
                         input logic [31:0] xd, input logic xm);
        exp_t e;
        @(negedge clk);
        bus.in_valid = v;
        bus.op       = op;
        bus.isu      = isu;
        bus.addr_lo  = a;
        bus.din      = din;
        if (v) begin
            e.v = 1'b1; e.dout = xd; e.mis = xm;
            last_dout = xd;
        end else begin
            e.v = 1'b0; e.dout = last_dout; e.mis = 1'b0;
        end
        sb.push_back(e);
        mon_en = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("out_valid", {31'b0, bus.out_valid}, {31'b0, e.v});
                chk("dout", bus.dout, e.dout);
                chk("misalign", {31'b0, bus.misalign}, {31'b0, e.mis});
            end
        end
    end

    function automatic vec_t mk(input logic [1:0] op, input logic isu, input logic [1:0] a,
                                input logic [31:0] din, input logic [31:0] d, input logic m);
        vec_t t;
        t.v = 1'b1; t.op = op; t.isu = isu; t.a = a; t.din = din; t.dout = d; t.mis = m;
        return t;
    endfunction

    initial begin
        exp_t e;
        logic [1:0]  rop, ra;
        logic        risu;
        logic [31:0] rdin;

        vecs.push_back(mk(2'd0, 1'b0, 2'd3, 32'h80FF7F01, 32'hFFFFFF80, 1'b0));
        vecs.push_back(mk(2'd0, 1'b1, 2'd3, 32'h80FF7F01, 32'h00000080, 1'b0));
        vecs.push_back(mk(2'd0, 1'b0, 2'd0, 32'h80FF7F01, 32'h00000001, 1'b0));
        vecs.push_back(mk(2'd0, 1'b0, 2'd1, 32'h80FF7F01, 32'h0000007F, 1'b0));
        vecs.push_back(mk(2'd0, 1'b0, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF, 1'b0));
        vecs.push_back(mk(2'd1, 1'b0, 2'd2, 32'h80017FFE, 32'hFFFF8001, 1'b0));
        vecs.push_back(mk(2'd1, 1'b1, 2'd2, 32'h80017FFE, 32'h00008001, 1'b0));
        vecs.push_back(mk(2'd1, 1'b0, 2'd0, 32'h80017FFE, 32'h00007FFE, 1'b0));
        vecs.push_back(mk(2'd3, 1'b0, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(2'd3, 1'b1, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(2'd2, 1'b1, 2'd1, 32'hDEADBEEF, 32'hBEEF0000, 1'b0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk(2'd1, 1'b1, 2'd1, 32'h12345678, 32'h00000000, 1'b1));
        vecs.push_back(mk(2'd3, 1'b0, 2'd2, 32'hDEADBEEF, 32'h00000000, 1'b1));
        vecs.push_back(mk(2'd1, 1'b0, 2'd3, 32'h80017FFE, 32'h00000000, 1'b1));
`else
        vecs.push_back(mk(2'd1, 1'b1, 2'd1, 32'h12345678, 32'h00005678, 1'b0));
        vecs.push_back(mk(2'd3, 1'b0, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(2'd1, 1'b0, 2'd3, 32'h80017FFE, 32'hFFFF8001, 1'b0));
`endif

        reset = 1'b0;
        bus.in_valid = 1'b0; bus.op = 2'd0; bus.isu = 1'b0; bus.addr_lo = 2'd0; bus.din = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout", bus.dout, 32'h0);
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("reset_misalign", {31'b0, bus.misalign}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // directed table, back-to-back, then a gap of two idle cycles
        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i].v, vecs[i].op, vecs[i].isu, vecs[i].a, vecs[i].din,
                  vecs[i].dout, vecs[i].mis);
        drive(1'b0, 2'd3, 1'b0, 2'd0, 32'h55555555, 32'h0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 2'd1, 32'hAAAAAAAA, 32'h0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            rop  = 2'($urandom_range(0, 3));
            ra   = 2'($urandom_range(0, 3));
            risu = 1'($urandom_range(0, 1));
            rdin = $urandom;
            e = model(rop, risu, ra, rdin);
            if ($urandom_range(0, 3) == 0)
                drive(1'b0, rop, risu, ra, rdin, 32'h0, 1'b0);
            else
                drive(1'b1, rop, risu, ra, rdin, e.dout, e.mis);
        end

        // asynchronous reset while a result is being presented
        drive(1'b1, 2'd0, 1'b0, 2'd3, 32'h80FF7F01, 32'hFFFFFF80, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_reset_out_valid", {31'b0, bus.out_valid}, 32'h1);
        mon_en = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_dout", bus.dout, 32'h0);
        chk("async_reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("async_reset_misalign", {31'b0, bus.misalign}, 32'h0);
        sb.delete();
        last_dout = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            chk("post_reset_idle_valid", {31'b0, bus.out_valid}, 32'h0);
            chk("post_reset_idle_dout", bus.dout, 32'h0);
        end

        drive(1'b1, 2'd2, 1'b0, 2'd0, 32'h0000CAFE, 32'hCAFE0000, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        chk("scoreboard_drained", sb.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ext_byte.md
Name: ext_byte

Overview:
- Load-data extension unit between the data memory read port and register-file writeback.
- Takes the raw 32-bit little-endian memory word, selects a byte, halfword or word by address offset, and sign- or zero-extends it to 32 bits.
- Also supports an upper-immediate mode.
- Result is registered: one-cycle latency with a valid flag.

Parameters:
- WIDTH, 32, data path width; only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request qualifier; sampled on the rising edge of clk.
- op  input  2  access size: 0 = byte (lb/lbu), 1 = halfword (lh/lhu), 2 = upper immediate, 3 = word (lw).
- isu  input  1  1 = zero-extend, 0 = sign-extend; ignored for op 2 and op 3.
- addr_lo  input  2  byte offset within the word (Addr[1:0]).
- din  input  32  raw memory word; byte k is din[8k+7:8k].
- dout  output  32  extended result, registered.
- out_valid  output  1  dout holds a new result for exactly this cycle.
- misalign  output  1  registered misaligned-access flag; constant 0 unless MISALIGN_TRAP_EN is defined.

Behaviour:
- Reset (reset=0, asynchronous): dout=0, out_valid=0, misalign=0 immediately. Outputs stay there while reset is low. Release is synchronous to the next clk edge.
- Latency: a request with in_valid=1 at edge N appears on dout/out_valid/misalign after edge N. No internal state beyond the output registers. A new request is accepted every cycle (no backpressure).
- in_valid=0 at an edge: out_valid<=0 and misalign<=0; dout holds its previous value.
- Byte (op 0):
  - b = din[8*addr_lo+7 : 8*addr_lo].
  - isu=0: dout = {24{b[7]}, b}.
  - isu=1: dout = {24'b0, b}.
- Halfword (op 1):
  - h = addr_lo[1] ? din[31:16] : din[15:0]; addr_lo[0] is ignored for selection.
  - isu=0: dout = {16{h[15]}, h}.
  - isu=1: dout = {16'b0, h}.
- Upper immediate (op 2): dout = {din[15:0], 16'b0}. addr_lo and isu are ignored.
- Word (op 3): dout = din. addr_lo and isu are ignored.
- Extraction and extension are purely combinational ahead of the single register stage. The extension logic contains no arithmetic and produces no carries or overflow.
- Reset asserted mid-stream: any pending result is discarded; out_valid=0 on release until the next accepted request.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - misalign is registered alongside out_valid.
  - It is 1 when the request has op=1 with addr_lo[0]=1, or op=3 with addr_lo!=0.
  - When misalign=1, dout is forced to 0 for that result and out_valid is still 1.
  - Byte accesses and op 2 are never misaligned.
- Not defined: misalign is tied to 0, no check logic is generated, and selection follows the Behaviour rules (low offset bits ignored).

Test Plan:
- Reset: drive reset=0 mid-operation with out_valid=1 -> dout=0, out_valid=0 at once without a clock edge. Release reset and hold in_valid=0 -> out_valid stays 0.
- Byte sign/zero:
  - din=32'h80FF7F01, op=0.
  - addr_lo=3, isu=0 -> dout=FFFFFF80.
  - isu=1 -> 00000080.
  - addr_lo=0, isu=0 -> 00000001.
  - Each result appears one cycle later with out_valid=1 for one cycle.
- Halfword:
  - din=32'h8001_7FFE, op=1.
  - addr_lo=2, isu=0 -> FFFF8001.
  - isu=1 -> 00008001.
  - addr_lo=0, isu=0 -> 00007FFE.
- Word and upper immediate:
  - din=32'hDEADBEEF, op=3, any isu -> DEADBEEF.
  - op=2 -> BEEF0000.
- Back-to-back and gaps: four consecutive in_valid cycles with differing ops -> four consecutive correct results. One cycle of in_valid=0 -> out_valid=0 and dout holds the last value.
- Misalign:
  - op=1, addr_lo=1, din=32'h12345678, isu=1.
  - Without MISALIGN_TRAP_EN -> dout=00005678, misalign=0.
  - With MISALIGN_TRAP_EN -> dout=0, misalign=1, out_valid=1.
  - op=3, addr_lo=2 with the macro defined -> misalign=1.
